// File: rtl/dualport_ram.sv
// ----------------------------------------------------------------------------
// dualport_ram
//   16 x 4 simple dual-port RAM: port A writes, port B reads with a one-cycle
//   registered read. After every reset an INIT sweep writes zero to each
//   address, one per cycle for 16 cycles. While the sweep runs, both ports
//   are locked out.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   rst_n    in   synchronous active-low reset
//   a_we     in   port A write request
//   a_addr   in   port A write address
//   a_din    in   port A write data
//   a_ready  out  port A can accept a write this cycle (inverse of busy)
//   b_re     in   port B read request
//   b_addr   in   port B read address
//   dout_b   out  port B registered read data; holds when no read is accepted
//   b_valid  out  dout_b was refreshed by a read accepted in the prior cycle
//   busy     out  initialisation sweep in progress
//
// Configuration
//   RAM_BYPASS_EN  defined  : a same-address write and read in one cycle
//                             return the new a_din (write-first)
//                  undefined: they return the old stored word (read-first)
//   In both builds, the memory holds a_din after the collision.
// ----------------------------------------------------------------------------
module dualport_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_ready,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] dout_b,
  output logic              b_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_acc_p0;
  logic              rd_acc_p0;
  logic [DATA_W-1:0] rd_word_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  // Sweep sequencing: one address per cycle. The write at the last address
  // hands over to RUN on the following edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (&cnt) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign busy    = (state == INIT);
  assign a_ready = ~busy;

  // ---- stage p0: request acceptance and array read ----
  // Requests are dropped, not queued, while the sweep runs.
  assign wr_acc_p0 = rst_n & a_we & ~busy;
  assign rd_acc_p0 = b_re & ~busy;

`ifdef RAM_BYPASS_EN
  assign rd_word_p0 = (wr_acc_p0 && (a_addr == b_addr)) ? a_din : mem[b_addr];
`else
  // The array update is non-blocking, so this returns the pre-write word.
  assign rd_word_p0 = mem[b_addr];
`endif

  // Storage has no reset. The sweep clears it before either port is usable.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wr_acc_p0)
      mem[a_addr] <= a_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= rd_acc_p0;
      if (rd_acc_p0) rd_data_p1 <= rd_word_p0;
    end
  end

  // ---- stage p1: registered read result ----
  assign dout_b  = rd_data_p1;
  assign b_valid = vld_p1;

endmodule

// File: tb/tb_dualport_ram.sv
module tb_dualport_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_we = 1'b0;
  logic [3:0] a_addr = '0;
  logic [3:0] a_din = '0;
  logic       a_ready;
  logic       b_re = 1'b0;
  logic [3:0] b_addr = '0;
  logic [3:0] dout_b;
  logic       b_valid;
  logic       busy;

  dualport_ram dut (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ready(a_ready),
    .b_re(b_re), .b_addr(b_addr), .dout_b(dout_b), .b_valid(b_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: contents, remaining lockout cycles, and expected outputs.
  logic [3:0] ref_mem [16];
  int         lock_left;
  logic       exp_vld;
  logic [3:0] exp_dout;
  logic [3:0] exp_q [$];
  logic       mon_en = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         busy_cycles;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle. Drive the inputs, take the edge, then update the model.
  task automatic cyc(input logic rst, input logic we, input logic [3:0] wa,
                     input logic [3:0] wd, input logic re, input logic [3:0] ra);
    logic [3:0] rv;
    rst_n = rst; a_we = we; a_addr = wa; a_din = wd; b_re = re; b_addr = ra;
    @(posedge clk);
    if (!rst) begin
      lock_left = 16;
      exp_vld   = 1'b0;
      exp_dout  = 4'h0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
    end else if (lock_left > 0) begin
      lock_left--;
      exp_vld = 1'b0;
    end else begin
      exp_vld = re;
      if (re) begin
        rv = ref_mem[ra];
`ifdef RAM_BYPASS_EN
        if (we && wa == ra) rv = wd;
`endif
        exp_dout = rv;
        exp_q.push_back(rv);
      end
      if (we) ref_mem[wa] = wd;
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
  endtask

  // Monitor: samples on the falling edge and scores every b_valid pulse.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", busy, lock_left > 0);
        check("a_ready", a_ready, lock_left == 0);
        check("b_valid", b_valid, exp_vld);
        if (b_valid) begin
          if (exp_q.size() == 0) check("unexpected_read", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("dout_b", dout_b, e);
          end
        end else begin
          check("dout_b_hold", dout_b, exp_dout);
        end
      end
    end
  end

  initial begin
    // Sweep after power-up reset.
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      idle(1);
      busy_cycles++;
    end
    check("sweep_length", busy_cycles, 16);
    for (int a = 0; a < 16; a++) cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'(a));
    idle(2);

    // Write and read back.
    cyc(1'b1, 1'b1, 4'd3, 4'hA, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'd12, 4'h5, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd3);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd12);
    idle(2);

    // Same-address collision, then a plain re-read.
    cyc(1'b1, 1'b1, 4'd7, 4'h2, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'd7, 4'h9, 1'b1, 4'd7);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd7);
    idle(2);

    // Requests made during the sweep are dropped.
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 4'd1, 4'hF, 1'b1, 4'd1);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd1);
    idle(2);

    // A reset pulse in the middle of a read burst.
    cyc(1'b1, 1'b1, 4'd4, 4'hC, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'd4);
    idle(2);

    // Streaming: reads of the low half, writes to the high half.
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(8, 15)),
          4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));

    // Fully random traffic, including collisions and occasional resets.
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 99) != 0), 1'($urandom), 4'($urandom),
          4'($urandom), 1'($urandom), 4'($urandom));
    idle(20);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
